seg7_scan_decoder: RTL
======================

# seg7_scan_decoder

Monitors a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and recovers the hexadecimal value being shown. It is the inverse of the team's hex-to-7-segment encoder: it filters scan glitches, decodes each stable segment pattern back to a nibble and assembles a multi-digit word. It sits on the display-observation path, used for self-check of display drivers and for loop-back of board display signals into logic.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 16, consecutive identical samples required before capture (≥2)
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- seg  in  7  segment lines, active-low, bit0=a … bit6=g
- an  in  NUM_DIGITS  digit enables, active-low, an[k] selects digit k
- clear  in  1  synchronous clear of captured state
- value  out  4*NUM_DIGITS  decoded digits, digit k at [4k+3:4k]
- digit_valid  out  NUM_DIGITS  digit k holds a legally decoded hex pattern
- digit_blank  out  NUM_DIGITS  digit k last captured as all-off (seg=7'h7F)
- bad_pattern  out  1  one-cycle pulse: captured pattern is neither a hex code nor blank
- frame_done  out  1  one-cycle pulse: every digit captured at least once since last frame

## Operation
- {an,seg} registered once into sample register s_q each cycle.
- Sample is "selectable" when exactly one bit of an is 0.
- FSM states SETTLE, HOLD. Reset state SETTLE, counter 0.
- SETTLE: if s_q differs from previous s_q or is not selectable → counter=0; else counter+1. When counter reaches STABLE_CYCLES-1 with the next sample unchanged and selectable → capture, go HOLD.
- HOLD: no further capture; any change in s_q → counter=0, SETTLE. Guarantees exactly one capture per stable dwell.
- Decode (active-low codes, hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E; blank=7F.
- Capture into digit k: hex hit → value[k]=nibble, valid[k]=1, blank[k]=0. Blank → value[k]=0, valid[k]=0, blank[k]=1. Other → value[k] unchanged, valid[k]=0, blank[k]=0, bad_pattern pulses.
- Frame mask seen[k] set on any capture of digit k. When all bits set → frame_done pulses, seen cleared. Recapture of same digit within a frame overwrites, no error.
- clear: value, digit_valid, digit_blank, seen, counter → 0, FSM → SETTLE; clear wins over a capture in the same cycle (capture discarded, no pulses).
- rst_n low mid-dwell or mid-frame: all state dropped immediately; nothing resumes.

## Timing
- Reset values: value=0, digit_valid=0, digit_blank=0, bad_pattern=0, frame_done=0.
- {an,seg} stable at pins before edge E0 → value/valid/blank/bad_pattern update on edge E0+STABLE_CYCLES.
- frame_done asserts on the edge after the completing capture, for one cycle.
- Dwell of STABLE_CYCLES samples or fewer → no capture, no outputs change.
- Multiple or zero anodes low → never captured regardless of duration.

## Structure
- Package seg7_pkg: the 16 active-low hex codes as constants, SEG7_BLANK=7'h7F, FSM state enum.
- Sub-module seg7_pattern_decode (combinational): seg → {hit, blank, nibble}; shares seg7_pkg constants with the encoder so tables cannot diverge.
- Top holds sample register, stability counter (width $clog2(STABLE_CYCLES)+1), FSM, capture/frame logic.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=4. Scan an=1110/seg=24, 1101/79, 1011/12, 0111/0E, 6 cycles each → value=16'hF512, digit_valid=4'hF, one frame_done.
- an=1110, seg=30 held 3 cycles then changed → no capture, value stays 0.
- an=1110, seg=7F held 6 cycles → digit_blank[0]=1, digit_valid[0]=0, value[3:0]=0.
- an=1101, seg=7F-like illegal 55 held 6 cycles → single bad_pattern pulse, digit_valid[1]=0, value[7:4] unchanged.
- an=1100 (two digits), seg=00 held 20 cycles → no capture, no pulses.
- Capture digit 2 with seg=00, assert clear on capture edge → value=0, valid=0, no pulses; rst_n low mid-frame → all outputs 0 asynchronously.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment code table, blank code and scan FSM states
package seg7_pkg;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic {SETTLE, HOLD} state_t;
    function automatic logic [6:0] seg7_encode(input logic [3:0] n);
        return SEG7_HEX[n];
    endfunction
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low segment pattern to hex nibble / blank flag
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);
    assign blank = seg == SEG7_BLANK;
    // reverse lookup through the encoder's own table
    always_comb begin
        hit = 1'b0;
        nibble = '0;
        for (int i = 0; i < 16; i++)
            if (seg == SEG7_HEX[i]) begin
                hit = 1'b1;
                nibble = 4'(i);
            end
    end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the hex word shown on a multiplexed active-low 7-seg bus
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    bad_pattern,
    output logic                    frame_done
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    logic [NUM_DIGITS+6:0] s_q, d;
    logic [NUM_DIGITS-1:0] seen, cap_mask;
    logic [CW-1:0] cnt, cnt_n;
    state_t state, state_n;
    logic same, sel, cap, hit, blk;
    logic [3:0] nib;
    assign d = {an, seg};
    assign same = d == s_q;
    assign sel = $onehot(~an);
    assign cap_mask = cap ? ~s_q[NUM_DIGITS+6:7] : '0;
    seg7_pattern_decode u_dec (.seg(s_q[6:0]), .hit(hit), .blank(blk), .nibble(nib));
    // stability counting: capture once the incoming sample repeats a full dwell
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cap = 1'b0;
        if (state == SETTLE) begin
            if (!same || !sel) cnt_n = '0;
            else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                cap = 1'b1;
                state_n = HOLD;
                cnt_n = '0;
            end else cnt_n = cnt + CW'(1);
        end else if (!same) begin
            state_n = SETTLE;
            cnt_n = '0;
        end
    end
    // sample register, FSM state and captured digit state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            state <= SETTLE;
            cnt <= '0;
            value <= '0;
            digit_valid <= '0;
            digit_blank <= '0;
            seen <= '0;
            bad_pattern <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            s_q <= d;
            if (clear) begin
                state <= SETTLE;
                cnt <= '0;
                value <= '0;
                digit_valid <= '0;
                digit_blank <= '0;
                seen <= '0;
                bad_pattern <= 1'b0;
                frame_done <= 1'b0;
            end else begin
                state <= state_n;
                cnt <= cnt_n;
                bad_pattern <= cap && !hit && !blk;
                frame_done <= &seen;
                seen <= ((&seen) ? '0 : seen) | cap_mask;
                for (int k = 0; k < NUM_DIGITS; k++)
                    if (cap_mask[k]) begin
                        if (hit) value[4*k +: 4] <= nib;
                        else if (blk) value[4*k +: 4] <= '0;
                        digit_valid[k] <= hit;
                        digit_blank[k] <= blk;
                    end
            end
        end
    end
endmodule
